// File: rtl/rom_tag_tx.sv
// rom_tag_tx: transmit-side packer for the odd-tag word format.
// Payloads of A-1 bits are accepted over a valid/ready handshake and buffered
// in a DEPTH-entry FIFO. A registered output stage presents each payload as
// {payload,1'b1}. An all-zero word means idle, so a zero payload (8'h01) can
// never be confused with idle (8'h00). The output word is held bit-exact while
// downstream stalls with out_rdy=0.
module rom_tag_tx #(
    parameter int A  = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [A-2:0]  in_data,
    input  logic          in_vld,
    output logic          in_rdy,
    output logic [A-1:0]  out_word,
    input  logic          out_rdy,
    output logic [AW:0]   fifo_cnt
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    // Output stage states; HOLD always coincides with out_word[0]=1.
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [A-2:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic [0:0]    state;
    logic [A-1:0]  word_q;

    logic          push;
    logic          pop;
    logic          out_free;
    logic          fifo_empty;
    logic          fifo_full;

    // Status flags come only from registered state so that in_rdy never
    // depends on out_rdy or in_vld in the same cycle.
    always_comb begin
        fifo_empty = (cnt == '0);
        fifo_full  = (cnt == FULL_CNT);
    end

    // Handshake decode: the output register is free when idle, or when the
    // held word is being transferred this cycle. A pop in the same cycle as a
    // full FIFO does not open room for a push, since in_rdy uses the old count.
    always_comb begin
        in_rdy   = !rst && !fifo_full;
        push     = in_vld && in_rdy;
        out_free = (state == IDLE) || out_rdy;
        pop      = out_free && !fifo_empty;
    end

    // FIFO storage; contents need no reset because the count and pointers
    // decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_data;
        end
    end

    // Write pointer wraps naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
        end else if (push) begin
            wptr <= wptr + 1'b1;
        end
    end

    // Read pointer advances each time the output register takes a payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr <= '0;
        end else if (pop) begin
            rptr <= rptr + 1'b1;
        end
    end

    // Occupancy count: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (push && !pop) begin
            cnt <= cnt + 1'b1;
        end else if (pop && !push) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Output stage: load the next tagged payload when free, fall back to the
    // idle word when nothing is buffered, otherwise hold the word stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            word_q <= '0;
        end else if (out_free) begin
            if (!fifo_empty) begin
                state  <= HOLD;
                word_q <= {mem[rptr], 1'b1};
            end else begin
                state  <= IDLE;
                word_q <= '0;
            end
        end
    end

    assign out_word = word_q;
    assign fifo_cnt = cnt;

endmodule

// File: tb/tb_rom_tag_tx.sv
// tb_rom_tag_tx: directed bench for rom_tag_tx with immediate-assertion checks.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_rom_tag_tx;

    logic       clk;
    logic       rst;
    logic [6:0] in_data;
    logic       in_vld;
    logic       in_rdy;
    logic [7:0] out_word;
    logic       out_rdy;
    logic [2:0] fifo_cnt;

    int checks;
    int errors;

    rom_tag_tx #(.A(8), .AW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .out_word (out_word),
        .out_rdy  (out_rdy),
        .fifo_cnt (fifo_cnt)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] d, input logic v, input logic r);
        in_data = d;
        in_vld  = v;
        out_rdy = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [6:0] exp_q [$];
    logic [6:0] pay [20];
    logic [6:0] rdy_pat;
    logic [6:0] exp_p;
    logic [7:0] drain1 [6];
    logic [7:0] drain2 [6];
    int         sent;
    int         got;
    int         cyc;
    logic       do_push;
    logic       do_xfer;

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        applyStimulus(7'h00, 1'b0, 1'b0);

        // Reset state
        tick();
        tick();
        checkOutput("reset_out_word", 32'(out_word), 32'h00);
        checkOutput("reset_fifo_cnt", 32'(fifo_cnt), 32'd0);
        checkOutput("reset_in_rdy", 32'(in_rdy), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_rdy", 32'(in_rdy), 32'd1);

        // Single word 7'h35 -> 8'h6B for one cycle
        applyStimulus(7'h35, 1'b1, 1'b1);
        tick();
        checkOutput("single_cnt_after_push", 32'(fifo_cnt), 32'd1);
        checkOutput("single_no_bypass", 32'(out_word), 32'h00);
        applyStimulus(7'h00, 1'b0, 1'b1);
        tick();
        checkOutput("single_word", 32'(out_word), 32'h6B);
        checkOutput("single_cnt_after_pop", 32'(fifo_cnt), 32'd0);
        tick();
        checkOutput("single_back_idle", 32'(out_word), 32'h00);

        // Zero then max payload
        applyStimulus(7'h00, 1'b1, 1'b1);
        tick();
        applyStimulus(7'h7F, 1'b1, 1'b1);
        tick();
        checkOutput("zero_payload_word", 32'(out_word), 32'h01);
        checkOutput("zero_payload_cnt", 32'(fifo_cnt), 32'd1);
        applyStimulus(7'h00, 1'b0, 1'b1);
        tick();
        checkOutput("max_payload_word", 32'(out_word), 32'hFF);
        tick();
        checkOutput("zero_max_idle", 32'(out_word), 32'h00);

        // Backpressure fill: push 1..7 with out_rdy low
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(7'(i), 1'b1, 1'b0);
            tick();
        end
        checkOutput("fill_cnt_full", 32'(fifo_cnt), 32'd4);
        checkOutput("fill_in_rdy_low", 32'(in_rdy), 32'd0);
        checkOutput("fill_word_stable", 32'(out_word), 32'h03);
        applyStimulus(7'h00, 1'b0, 1'b0);
        tick();
        checkOutput("fill_word_held", 32'(out_word), 32'h03);
        drain1[0] = 8'h03; drain1[1] = 8'h05; drain1[2] = 8'h07;
        drain1[3] = 8'h09; drain1[4] = 8'h0B; drain1[5] = 8'h00;
        applyStimulus(7'h00, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("drain1_%0d", i), 32'(out_word), 32'(drain1[i]));
            tick();
        end
        checkOutput("drain1_cnt", 32'(fifo_cnt), 32'd0);

        // Full with simultaneous pop and attempted push
        for (int i = 0; i < 5; i++) begin
            applyStimulus(7'(8'h10 + i), 1'b1, 1'b0);
            tick();
        end
        checkOutput("refill_cnt", 32'(fifo_cnt), 32'd4);
        checkOutput("refill_word", 32'(out_word), 32'h21);
        applyStimulus(7'h15, 1'b1, 1'b1);
        checkOutput("full_in_rdy_before", 32'(in_rdy), 32'd0);
        tick();
        checkOutput("full_pop_no_push_cnt", 32'(fifo_cnt), 32'd3);
        checkOutput("full_pop_word", 32'(out_word), 32'h23);
        checkOutput("full_in_rdy_after", 32'(in_rdy), 32'd1);
        applyStimulus(7'h15, 1'b1, 1'b0);
        tick();
        checkOutput("full_retry_push_cnt", 32'(fifo_cnt), 32'd4);
        drain2[0] = 8'h23; drain2[1] = 8'h25; drain2[2] = 8'h27;
        drain2[3] = 8'h29; drain2[4] = 8'h2B; drain2[5] = 8'h00;
        applyStimulus(7'h00, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("drain2_%0d", i), 32'(out_word), 32'(drain2[i]));
            tick();
        end

        // Wrap-around stream of 20 payloads with patterned out_rdy
        for (int i = 0; i < 20; i++) begin
            pay[i] = 7'((i * 37 + 5) % 128);
        end
        rdy_pat = 7'b1011001;
        sent = 0;
        got  = 0;
        cyc  = 0;
        exp_q.delete();
        while (got < 20 && cyc < 300) begin
            applyStimulus((sent < 20) ? pay[sent] : 7'h00, (sent < 20), rdy_pat[cyc % 7]);
            do_push = in_vld && in_rdy;
            do_xfer = out_word[0] && out_rdy;
            if (do_xfer) begin
                if (exp_q.size() > 0) begin
                    exp_p = exp_q.pop_front();
                    checkOutput($sformatf("stream_%0d", got), 32'(out_word), 32'({exp_p, 1'b1}));
                end else begin
                    checkOutput("stream_unexpected_word", 32'(out_word), 32'h00);
                end
                got++;
            end
            if (do_push) begin
                exp_q.push_back(pay[sent]);
                sent++;
            end
            tick();
            cyc++;
        end
        checkOutput("stream_all_received", 32'(got), 32'd20);
        checkOutput("stream_all_sent", 32'(sent), 32'd20);
        applyStimulus(7'h00, 1'b0, 1'b1);
        tick();
        checkOutput("stream_idle_word", 32'(out_word), 32'h00);
        checkOutput("stream_idle_cnt", 32'(fifo_cnt), 32'd0);

        // Reset mid-operation with 3 entries buffered and 8'h6B held
        applyStimulus(7'h35, 1'b1, 1'b0);
        tick();
        applyStimulus(7'h01, 1'b1, 1'b0);
        tick();
        applyStimulus(7'h02, 1'b1, 1'b0);
        tick();
        applyStimulus(7'h03, 1'b1, 1'b0);
        tick();
        checkOutput("midrst_pre_word", 32'(out_word), 32'h6B);
        checkOutput("midrst_pre_cnt", 32'(fifo_cnt), 32'd3);
        rst = 1'b1;
        applyStimulus(7'h44, 1'b1, 1'b0);
        #1;
        checkOutput("midrst_in_rdy_during", 32'(in_rdy), 32'd0);
        tick();
        checkOutput("midrst_word", 32'(out_word), 32'h00);
        checkOutput("midrst_cnt", 32'(fifo_cnt), 32'd0);
        checkOutput("midrst_in_rdy_held", 32'(in_rdy), 32'd0);
        rst = 1'b0;
        applyStimulus(7'h00, 1'b0, 1'b1);
        #1;
        checkOutput("midrst_in_rdy_after", 32'(in_rdy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("midrst_no_stale_%0d", i), 32'(out_word), 32'h00);
        end
        applyStimulus(7'h2A, 1'b1, 1'b1);
        tick();
        applyStimulus(7'h00, 1'b0, 1'b1);
        tick();
        checkOutput("midrst_fresh_word", 32'(out_word), 32'h55);
        tick();
        checkOutput("midrst_fresh_idle", 32'(out_word), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
